// File: rtl/exec_multiplier_pipe_if.sv
// Operation encodings and the issue/result bundle between the execute stage
// and the pipelined multiplier.
package exec_mul_pkg;
  typedef enum logic [2:0] {
    ALUOP_ALU = 3'd0,
    ALUOP_MUL = 3'd1,
    ALUOP_DIV = 3'd2,
    ALUOP_LS  = 3'd3,
    ALUOP_BR  = 3'd4
  } aluop_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_MUL    = 4'd8,
    ALU_MULH   = 4'd9,
    ALU_MULHSU = 4'd10,
    ALU_MULHU  = 4'd11
  } alucontrol_t;
endpackage

interface exec_multiplier_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic                      flush;
  logic                      stall;
  logic                      ex_fire;
  exec_mul_pkg::aluop_t      aluop;
  exec_mul_pkg::alucontrol_t alucontrol;
  logic [XLEN-1:0]           in_a;
  logic [XLEN-1:0]           in_b;
  logic [TAG_W-1:0]          in_tag;
  logic                      mul_valid;
  logic [XLEN-1:0]           mulresult;
  logic [TAG_W-1:0]          mul_tag;
  logic                      mul_busy;

  modport master (
    output flush, stall, ex_fire, aluop, alucontrol, in_a, in_b, in_tag,
    input  mul_valid, mulresult, mul_tag, mul_busy
  );
  modport slave (
    input  flush, stall, ex_fire, aluop, alucontrol, in_a, in_b, in_tag,
    output mul_valid, mulresult, mul_tag, mul_busy
  );
endinterface

// File: rtl/exec_multiplier_pipe.sv
// Fully pipelined RV32M/RV64M multiplier: stage 1 captures extended operands,
// the product is registered through the middle stages, the output register selects the half.
module exec_multiplier_pipe
  import exec_mul_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input logic                   clk,
  input logic                   start,
  exec_multiplier_pipe_if.slave mif
);
  localparam int PW = 2 * XLEN;

  if ((XLEN != 32 && XLEN != 64) || STAGES < 2) begin : g_bad_param
    $error("exec_multiplier_pipe: XLEN must be 32/64 and STAGES >= 2");
  end

  typedef struct packed {
    alucontrol_t      op;
    logic [TAG_W-1:0] tag;
  } ctl_t;

  logic              accept;
  logic [STAGES:1]   vld_pipe;
  ctl_t              ctl_q [1:STAGES-1];
  logic              sgn_a, sgn_b;
  logic [XLEN:0]     ext_a, ext_b, a1, b1;
  logic [PW+1:0]     prod_full;
  logic [PW-1:0]     prod_last;
  logic [XLEN-1:0]   sel, res_q;
  logic [TAG_W-1:0]  tag_q;
  logic              unused_prod_hi;

  assign accept = mif.ex_fire && (mif.aluop == ALUOP_MUL) && !mif.stall && !mif.flush;

  // rs1 is unsigned only for MULHU; rs2 is signed only for MUL/MULH
  assign sgn_a = (mif.alucontrol != ALU_MULHU);
  assign sgn_b = (mif.alucontrol == ALU_MUL) || (mif.alucontrol == ALU_MULH);
  assign ext_a = {sgn_a & mif.in_a[XLEN-1], mif.in_a};
  assign ext_b = {sgn_b & mif.in_b[XLEN-1], mif.in_b};

  always_ff @(posedge clk or negedge start) begin
    if (!start)              vld_pipe <= '0;
    else if (mif.flush)      vld_pipe <= '0;
    else if (!mif.stall)     vld_pipe <= {vld_pipe[STAGES-1:1], accept};
  end

  // Payload registers carry garbage under bubbles; only the valid bits matter.
  always_ff @(posedge clk) begin
    if (!mif.stall) begin
      a1       <= ext_a;
      b1       <= ext_b;
      ctl_q[1] <= '{op: mif.alucontrol, tag: mif.in_tag};
      for (int s = 2; s < STAGES; s++) ctl_q[s] <= ctl_q[s-1];
    end
  end

  // Signed (XLEN+1)^2 product via sign-extended unsigned multiply; top 2 bits dropped.
  assign prod_full = {{(XLEN+1){a1[XLEN]}}, a1} * {{(XLEN+1){b1[XLEN]}}, b1};
  assign unused_prod_hi = ^prod_full[PW+1:PW];

  if (STAGES > 2) begin : g_prod
    logic [PW-1:0] prod_q [2:STAGES-1];
    always_ff @(posedge clk) begin
      if (!mif.stall) begin
        prod_q[2] <= prod_full[PW-1:0];
        for (int s = 3; s < STAGES; s++) prod_q[s] <= prod_q[s-1];
      end
    end
    assign prod_last = prod_q[STAGES-1];
  end else begin : g_noprod
    assign prod_last = prod_full[PW-1:0];
  end

  always_comb begin
    sel = '0;
    case (ctl_q[STAGES-1].op)
      ALU_MUL:                         sel = prod_last[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: sel = prod_last[PW-1:XLEN];
      default:                         sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      res_q <= '0;
      tag_q <= '0;
    end else if (mif.flush) begin
      res_q <= '0;
      tag_q <= '0;
    end else if (!mif.stall && vld_pipe[STAGES-1]) begin
      res_q <= sel;
      tag_q <= ctl_q[STAGES-1].tag;
    end
  end

  assign mif.mul_valid = vld_pipe[STAGES];
  assign mif.mulresult = res_q;
  assign mif.mul_tag   = tag_q;
  assign mif.mul_busy  = |vld_pipe[STAGES-1:1];
endmodule

// File: tb/tb_exec_multiplier_pipe.sv
// Directed bench: queue-based latency model checked every cycle, plus literal
// result/tag/cycle expectations per scenario and a separate XLEN=64 instance.
module tb_exec_multiplier_pipe;
  import exec_mul_pkg::*;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  exec_multiplier_pipe_if #(.XLEN(32), .TAG_W(5)) mif ();
  exec_multiplier_pipe_if #(.XLEN(64), .TAG_W(5)) mif64 ();

  exec_multiplier_pipe #(.XLEN(32), .STAGES(ST), .TAG_W(5)) dut (
    .clk(clk), .start(start), .mif(mif.slave));
  exec_multiplier_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) dut64 (
    .clk(clk), .start(start), .mif(mif64.slave));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc0 = 0;

  typedef struct { logic [31:0] res; logic [4:0] tag; int left; } op_t;
  typedef struct { logic [31:0] res; logic [4:0] tag; int cyc; } ent_t;
  op_t  fl[$];
  op_t  done_op;
  ent_t lg[$];
  logic [31:0] er[$];
  logic [4:0]  et[$];
  logic        m_vld = 1'b0, m_busy = 1'b0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_tag = '0;
  logic [63:0] tmp;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mathematical product of the operands read as signed/unsigned integers.
  function automatic logic [63:0] ref_mul(alucontrol_t c, logic [63:0] a, logic [63:0] b, int xl);
    logic signed [129:0] va, vb, p;
    logic as, bs;
    as = (c == ALU_MUL) || (c == ALU_MULH) || (c == ALU_MULHSU);
    bs = (c == ALU_MUL) || (c == ALU_MULH);
    if (xl == 32) begin
      va = {{98{as & a[31]}}, a[31:0]};
      vb = {{98{bs & b[31]}}, b[31:0]};
    end else begin
      va = {{66{as & a[63]}}, a};
      vb = {{66{bs & b[63]}}, b};
    end
    p = va * vb;
    case (c)
      ALU_MUL:                         return (xl == 32) ? {32'b0, p[31:0]}  : p[63:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: return (xl == 32) ? {32'b0, p[63:32]} : p[127:64];
      default:                         return 64'b0;
    endcase
  endfunction

  always @(negedge start) begin
    fl.delete();
    m_vld = 0; m_res = '0; m_tag = '0; m_busy = 0;
  end

  // Model: each accepted op completes after ST-1 unstalled edges; flush empties it.
  always @(posedge clk) begin
    cyc++;
    if (start) begin
      if (mif.flush) begin
        fl.delete();
        m_vld = 0; m_res = '0; m_tag = '0;
      end else if (!mif.stall) begin
        m_vld = 0;
        foreach (fl[i]) fl[i].left--;
        if (fl.size() > 0 && fl[0].left == 0) begin
          done_op = fl.pop_front();
          m_vld = 1; m_res = done_op.res; m_tag = done_op.tag;
        end
        if (mif.ex_fire && mif.aluop == ALUOP_MUL) begin
          tmp = ref_mul(mif.alucontrol, {32'b0, mif.in_a}, {32'b0, mif.in_b}, 32);
          fl.push_back('{tmp[31:0], mif.in_tag, ST - 1});
        end
      end
      m_busy = (fl.size() != 0);
    end
    #1;
    chk("valid", {63'b0, mif.mul_valid}, {63'b0, m_vld});
    chk("busy", {63'b0, mif.mul_busy}, {63'b0, m_busy});
    chk("result", {32'b0, mif.mulresult}, {32'b0, m_res});
    chk("tag", {59'b0, mif.mul_tag}, {59'b0, m_tag});
    if (mif.mul_valid) lg.push_back('{mif.mulresult, mif.mul_tag, cyc});
  end

  task automatic issue(aluop_t op, alucontrol_t c, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
    @(negedge clk);
    mif.ex_fire = 1; mif.aluop = op; mif.alucontrol = c;
    mif.in_a = a; mif.in_b = b; mif.in_tag = tag;
    mif.stall = 0; mif.flush = 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      mif.ex_fire = 0; mif.stall = 0; mif.flush = 0;
    end
  endtask

  task automatic check_log(string name, int first);
    chk({name, "_count"}, 64'(lg.size()), 64'(er.size()));
    for (int i = 0; i < er.size() && i < lg.size(); i++) begin
      chk({name, "_res"}, {32'b0, lg[i].res}, {32'b0, er[i]});
      chk({name, "_tag"}, {59'b0, lg[i].tag}, {59'b0, et[i]});
      chk({name, "_cyc"}, 64'(lg[i].cyc), 64'(first + i));
    end
    lg.delete(); er.delete(); et.delete();
  endtask

  initial begin
    mif.flush = 0; mif.stall = 0; mif.ex_fire = 0; mif.aluop = ALUOP_ALU;
    mif.alucontrol = ALU_ADD; mif.in_a = '0; mif.in_b = '0; mif.in_tag = '0;
    mif64.flush = 0; mif64.stall = 0; mif64.ex_fire = 0; mif64.aluop = ALUOP_ALU;
    mif64.alucontrol = ALU_ADD; mif64.in_a = '0; mif64.in_b = '0; mif64.in_tag = '0;
    #2;
    chk("rst_valid", {63'b0, mif.mul_valid}, 64'd0);
    chk("rst_busy", {63'b0, mif.mul_busy}, 64'd0);
    chk("rst_result", {32'b0, mif.mulresult}, 64'd0);
    chk("rst_tag", {59'b0, mif.mul_tag}, 64'd0);
    #10 start = 1;
    idle(1);

    // Corner products, back-to-back
    issue(ALUOP_MUL, ALU_MUL,    32'hFFFFFFFF, 32'h2, 5'd1); acc0 = cyc + 1;
    issue(ALUOP_MUL, ALU_MULH,   32'hFFFFFFFF, 32'h2, 5'd2);
    issue(ALUOP_MUL, ALU_MULHSU, 32'hFFFFFFFF, 32'h2, 5'd3);
    issue(ALUOP_MUL, ALU_MULHU,  32'hFFFFFFFF, 32'h2, 5'd4);
    idle(5);
    er = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    et = '{5'd1, 5'd2, 5'd3, 5'd4};
    check_log("corner", acc0 + 2);

    // Signed extremes
    issue(ALUOP_MUL, ALU_MULH,   32'h80000000, 32'h80000000, 5'd5); acc0 = cyc + 1;
    issue(ALUOP_MUL, ALU_MULHU,  32'h80000000, 32'h80000000, 5'd6);
    issue(ALUOP_MUL, ALU_MUL,    32'h80000000, 32'h80000000, 5'd7);
    issue(ALUOP_MUL, ALU_MULHSU, 32'h80000000, 32'h80000000, 5'd8);
    idle(5);
    er = '{32'h40000000, 32'h40000000, 32'h00000000, 32'hC0000000};
    et = '{5'd5, 5'd6, 5'd7, 5'd8};
    check_log("extreme", acc0 + 2);

    // Stall: 3 stalled edges after accept, then 2 more while held at the output;
    // an issue attempted during the stall must be ignored.
    issue(ALUOP_MUL, ALU_MUL, 32'd7, 32'd6, 5'd5); acc0 = cyc + 1;
    issue(ALUOP_MUL, ALU_MUL, 32'd3, 32'd3, 5'd9); mif.stall = 1;
    repeat (2) @(negedge clk);
    @(negedge clk); mif.stall = 0; mif.ex_fire = 0;
    @(negedge clk);
    @(negedge clk); mif.stall = 1;
    @(negedge clk);
    idle(3);
    er = '{32'd42, 32'd42, 32'd42};
    et = '{5'd5, 5'd5, 5'd5};
    check_log("stall", acc0 + 5);

    // Flush on the edge the first op would complete; simultaneous issue dropped
    issue(ALUOP_MUL, ALU_MUL, 32'd2, 32'd3, 5'd10);
    issue(ALUOP_MUL, ALU_MUL, 32'd4, 32'd5, 5'd11);
    issue(ALUOP_MUL, ALU_MUL, 32'd6, 32'd7, 5'd12); mif.flush = 1;
    @(negedge clk);
    chk("flush_valid", {63'b0, mif.mul_valid}, 64'd0);
    chk("flush_result", {32'b0, mif.mulresult}, 64'd0);
    chk("flush_tag", {59'b0, mif.mul_tag}, 64'd0);
    chk("flush_busy", {63'b0, mif.mul_busy}, 64'd0);
    mif.flush = 0; mif.ex_fire = 0;
    idle(4);
    check_log("flush", 0);

    // Non-MUL aluop ignored; unknown alucontrol yields 0
    issue(ALUOP_ALU, ALU_MUL, 32'd4, 32'd4, 5'd13);
    issue(ALUOP_MUL, ALU_ADD, 32'd5, 32'd6, 5'd14); acc0 = cyc + 1;
    idle(4);
    er = '{32'd0};
    et = '{5'd14};
    check_log("unknown", acc0 + 2);

    // Asynchronous reset with two ops in flight
    issue(ALUOP_MUL, ALU_MUL,   32'd9, 32'd9, 5'd20);
    issue(ALUOP_MUL, ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
    @(negedge clk); mif.ex_fire = 0;
    chk("pre_rst_busy", {63'b0, mif.mul_busy}, 64'd1);
    #2 start = 0;
    #1;
    chk("arst_valid", {63'b0, mif.mul_valid}, 64'd0);
    chk("arst_busy", {63'b0, mif.mul_busy}, 64'd0);
    chk("arst_result", {32'b0, mif.mulresult}, 64'd0);
    chk("arst_tag", {59'b0, mif.mul_tag}, 64'd0);
    #1 start = 1;
    idle(5);
    check_log("reset", 0);

    // XLEN=64, STAGES=2: result one edge after accept
    @(negedge clk);
    mif64.ex_fire = 1; mif64.aluop = ALUOP_MUL; mif64.alucontrol = ALU_MULHU;
    mif64.in_a = '1; mif64.in_b = '1; mif64.in_tag = 5'd3;
    @(negedge clk);
    mif64.alucontrol = ALU_MUL; mif64.in_a = 64'hFFFF_FFFF_FFFF_FFFD;
    mif64.in_b = 64'd5; mif64.in_tag = 5'd4;
    @(negedge clk);
    chk("x64_valid0", {63'b0, mif64.mul_valid}, 64'd1);
    chk("x64_mulhu", mif64.mulresult, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("x64_mulhu_model", mif64.mulresult, ref_mul(ALU_MULHU, '1, '1, 64));
    chk("x64_tag0", {59'b0, mif64.mul_tag}, 64'd3);
    mif64.ex_fire = 0;
    @(negedge clk);
    chk("x64_valid1", {63'b0, mif64.mul_valid}, 64'd1);
    chk("x64_mul", mif64.mulresult, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("x64_tag1", {59'b0, mif64.mul_tag}, 64'd4);
    @(negedge clk);
    chk("x64_pulse", {63'b0, mif64.mul_valid}, 64'd0);
    chk("x64_busy", {63'b0, mif64.mul_busy}, 64'd0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
